// File: rtl/regs_fifo_arb_ctrl_pkg.sv
// Shared constants and types for the two-requester frame FIFO controller.
package regs_fifo_arb_ctrl_pkg;

   localparam int ADDR_DEF   = 12;
   localparam int WORDS_DEF  = 4096;
   localparam int W_SIZE_DEF = 36;
   localparam int EOP_BIT    = W_SIZE_DEF - 1;
   localparam int DELAYTIME  = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   function automatic arb_state_e own_state(input logic sel);
      return sel ? OWN1 : OWN0;
   endfunction

endpackage

// File: rtl/regs_fifo_arb_ctrl_rr_frame_arb.sv
// Frame-granular round-robin arbiter: once a requester starts a frame it keeps
// the grant until its EOP word is accepted.
//   state | meaning
//   IDLE  | no frame open; grant decided combinationally from valids/last_grant
//   OWN0  | requester 0 has an open frame, requester 1 held off
//   OWN1  | requester 1 has an open frame, requester 0 held off
module rr_frame_arb
   import regs_fifo_arb_ctrl_pkg::*;
(
   input  logic       arb_clk,
   input  logic       arb_rst_n,
   input  logic [1:0] valid_i,
   input  logic [1:0] eop_i,
   input  logic       full_i,
   output logic [1:0] ready_o,
   output logic       sel_o
);

   arb_state_e state_q, state_d;
   logic       last_grant_q, last_grant_d;
   logic       accept;

   assign accept = |(valid_i & ready_o);

   always_ff @(posedge arb_clk or negedge arb_rst_n) begin
      if (!arb_rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (eop_i[sel_o]) last_grant_d = sel_o;
               else              state_d      = own_state(sel_o);
            end
         end
         OWN0, OWN1: begin
            if (accept && eop_i[sel_o]) begin
               state_d      = IDLE;
               last_grant_d = sel_o;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // In IDLE a lone valid requester wins; a tie goes to whoever did not finish last.
   always_comb begin
      sel_o   = 1'b0;
      ready_o = 2'b00;
      case (state_q)
         IDLE: begin
            if (valid_i[0] && valid_i[1]) sel_o = ~last_grant_q;
            else                          sel_o = valid_i[1];
            ready_o = {sel_o, ~sel_o} & valid_i & {2{~full_i}};
         end
         OWN0: begin
            sel_o   = 1'b0;
            ready_o = {1'b0, ~full_i};
         end
         OWN1: begin
            sel_o   = 1'b1;
            ready_o = {~full_i, 1'b0};
         end
         default: begin
            sel_o   = 1'b0;
            ready_o = 2'b00;
         end
      endcase
   end

endmodule

// File: rtl/regs_fifo_arb_ctrl.sv
// Frame FIFO controller over a shared single-clock register memory with a
// registered read port; two requesters, one consumer.
module regs_fifo_arb_ctrl
   import regs_fifo_arb_ctrl_pkg::*;
#(
   parameter int ADDR   = ADDR_DEF,
   parameter int WORDS  = WORDS_DEF,
   parameter int W_SIZE = W_SIZE_DEF
) (
   input  logic              arb_clk,
   input  logic              arb_rst_n,
   input  logic              req0_valid,
   input  logic [W_SIZE-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [W_SIZE-1:0] req1_data,
   output logic              req1_ready,
   output logic              rd_valid,
   output logic [W_SIZE-1:0] rd_data,
   input  logic              rd_ready,
   output logic              mem_wen,
   output logic [ADDR-1:0]   mem_waddr,
   output logic [W_SIZE-1:0] mem_wdata,
   output logic [ADDR-1:0]   mem_raddr,
   input  logic [W_SIZE-1:0] mem_rdata,
   output logic [ADDR:0]     fifo_count,
   output logic              fifo_full,
   output logic              fifo_empty
);

   localparam int            EOP      = W_SIZE - 1;
   localparam logic [ADDR:0] FULL_CNT = (ADDR + 1)'(WORDS);

   logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR:0]   count_q, count_d;
   logic [ADDR:0]   vis_cnt_q, vis_cnt_d;
   logic            write_lag_q, rdreg_lag_q;
   logic [1:0]      ready;
   logic            sel;
   logic            push, pop;

   rr_frame_arb u_arb (
      .arb_clk   (arb_clk),
      .arb_rst_n (arb_rst_n),
      .valid_i   ({req1_valid, req0_valid}),
      .eop_i     ({req1_data[EOP], req0_data[EOP]}),
      .full_i    (fifo_full),
      .ready_o   (ready),
      .sel_o     (sel)
   );

   assign req0_ready = ready[0];
   assign req1_ready = ready[1];

   assign push = |({req1_valid, req0_valid} & ready);
   assign pop  = rd_valid & rd_ready;

   assign mem_wen   = push;
   assign mem_waddr = wr_ptr_q;
   assign mem_wdata = push ? (sel ? req1_data : req0_data) : '0;

   // Look ahead so the read register already holds the next word after a pop.
   assign mem_raddr = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

   assign rd_data    = mem_rdata;
   assign rd_valid   = (vis_cnt_q != '0);
   assign fifo_count = count_q;
   assign fifo_full  = (count_q == FULL_CNT);
   assign fifo_empty = (count_q == '0);

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // A word becomes poppable two edges after its write: one for write_lag,
   // one for the memory's read register to pick it up.
   always_comb begin
      vis_cnt_d = vis_cnt_q + {{ADDR{1'b0}}, rdreg_lag_q} - {{ADDR{1'b0}}, pop};
   end

   always_ff @(posedge arb_clk or negedge arb_rst_n) begin
      if (!arb_rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         vis_cnt_q   <= '0;
         write_lag_q <= 1'b0;
         rdreg_lag_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         vis_cnt_q   <= vis_cnt_d;
         write_lag_q <= push;
         rdreg_lag_q <= write_lag_q;
      end
   end

   a_no_push_full: assert property (@(posedge arb_clk) disable iff (!arb_rst_n)
      !(push && fifo_full));
   a_no_pop_empty: assert property (@(posedge arb_clk) disable iff (!arb_rst_n)
      !(pop && fifo_empty));
   a_one_ready: assert property (@(posedge arb_clk) disable iff (!arb_rst_n)
      !(ready[0] && ready[1]));
   a_vis_le_count: assert property (@(posedge arb_clk) disable iff (!arb_rst_n)
      vis_cnt_q <= count_q);

endmodule

// File: tb/tb_regs_fifo_arb_ctrl.sv
// Directed bench for regs_fifo_arb_ctrl with a behavioural registered-read memory.
module tb_regs_fifo_arb_ctrl;

   localparam int ADDR  = 12;
   localparam int WORDS = 4096;
   localparam int W     = 36;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0]    req0_data, req1_data;
   logic            rd_valid, rd_ready;
   logic [W-1:0]    rd_data;
   logic            mem_wen;
   logic [ADDR-1:0] mem_waddr, mem_raddr;
   logic [W-1:0]    mem_wdata, mem_rdata;
   logic [ADDR:0]   fifo_count;
   logic            fifo_full, fifo_empty;

   logic [W-1:0]    mem [WORDS];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   regs_fifo_arb_ctrl dut (
      .arb_clk    (clk),
      .arb_rst_n  (rst_n),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .rd_ready   (rd_ready),
      .mem_wen    (mem_wen),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .mem_raddr  (mem_raddr),
      .mem_rdata  (mem_rdata),
      .fifo_count (fifo_count),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_rdata <= '0;
      end else begin
         if (mem_wen) mem[mem_waddr] <= mem_wdata;
         mem_rdata <= mem[mem_raddr];
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req0_valid = 1'b0; req1_valid = 1'b0; rd_ready = 1'b0;
      req0_data  = '0;   req1_data  = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   function automatic logic [W-1:0] fw(input int r, input int f, input int w);
      logic [W-1:0] v;
      v = W'(r * 256 + f * 16 + w);
      v[W-1] = (w == 2);
      return v;
   endfunction

   logic [W-1:0] got_q[$];
   logic [W-1:0] prev_data, exp_w;
   logic         a0, a1, hold;
   int i0, i1, both, acc, n, bad, bad_cnt, s, r, unstable;
   logic [ADDR-1:0] last_waddr;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      req0_valid = 1'b0; req1_valid = 1'b0; rd_ready = 1'b0;
      req0_data  = '0;   req1_data  = '0;
      #2 rst_n = 1'b0;
      #2;
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_rd_valid",   rd_valid,   0);
      chk("rst_mem_wen",    mem_wen,    0);
      chk("rst_mem_waddr",  mem_waddr,  0);
      chk("rst_mem_raddr",  mem_raddr,  0);
      chk("rst_mem_wdata",  mem_wdata,  0);
      chk("rst_count",      fifo_count, 0);
      chk("rst_empty",      fifo_empty, 1);
      chk("rst_full",       fifo_full,  0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // single EOP word, latency and pop
      req0_valid = 1'b1; req0_data = 36'h8_0000_0001; #1;
      chk("t1_ready", req0_ready, 1);
      chk("t1_wen",   mem_wen,    1);
      chk("t1_waddr", mem_waddr,  0);
      chk("t1_wdata", mem_wdata,  36'h8_0000_0001);
      step(); req0_valid = 1'b0; #1;
      chk("t1_valid_e0", rd_valid,   0);
      chk("t1_count1",   fifo_count, 1);
      step(); #1;
      chk("t1_valid_e1", rd_valid, 0);
      step(); #1;
      chk("t1_valid_e2", rd_valid, 1);
      chk("t1_data",     rd_data,  36'h8_0000_0001);
      rd_ready = 1'b1; #1;
      chk("t1_raddr_la", mem_raddr, 1);
      step(); rd_ready = 1'b0; #1;
      chk("t1_count0", fifo_count, 0);
      chk("t1_empty",  fifo_empty, 1);
      chk("t1_valid0", rd_valid,   0);

      // two requesters, 3-word frames, no interleave
      do_reset();
      i0 = 0; i1 = 0; both = 0; got_q.delete();
      for (int cyc = 0; cyc < 200 && got_q.size() < 12; cyc++) begin
         req0_valid = (i0 < 6); req0_data = fw(0, i0 / 3, i0 % 3);
         req1_valid = (i1 < 6); req1_data = fw(1, i1 / 3, i1 % 3);
         rd_ready = 1'b1;
         #1;
         a0 = req0_valid && req0_ready;
         a1 = req1_valid && req1_ready;
         if (a0 && a1) both++;
         if (rd_valid) got_q.push_back(rd_data);
         step();
         if (a0) i0++;
         if (a1) i1++;
      end
      req0_valid = 1'b0; req1_valid = 1'b0; rd_ready = 1'b0;
      chk("t2_both_acc", both, 0);
      chk("t2_n_words", got_q.size(), 12);
      for (int k = 0; k < 12 && k < got_q.size(); k++)
         chk($sformatf("t2_word%0d", k), got_q[k], fw((k / 3) % 2, k / 6, k % 3));

      // fill to full, pop one, exactly one more push with address wrap
      do_reset();
      acc = 0; last_waddr = '0;
      for (int cyc = 0; cyc < 5000 && acc < WORDS; cyc++) begin
         req0_valid = 1'b1; req0_data = {1'b1, 23'd0, 12'(acc)};
         #1;
         if (req0_ready) begin
            last_waddr = mem_waddr;
            acc++;
         end
         step();
      end
      req0_valid = 1'b0;
      chk("t3_pushed",     acc,        WORDS);
      chk("t3_last_waddr", last_waddr, 4095);
      chk("t3_full",       fifo_full,  1);
      chk("t3_count",      fifo_count, WORDS);
      req0_valid = 1'b1; req0_data = 36'h8_0000_0DEF;
      req1_valid = 1'b1; req1_data = 36'h8_0000_0ABC;
      #1;
      chk("t3_full_r0", req0_ready, 0);
      chk("t3_full_r1", req1_ready, 0);
      chk("t3_full_wen", mem_wen, 0);
      rd_ready = 1'b1; #1;
      chk("t3_pop_valid", rd_valid, 1);
      chk("t3_pop_data",  rd_data,  {1'b1, 23'd0, 12'd0});
      chk("t3_pop_blk_r1", req1_ready, 0);
      step(); rd_ready = 1'b0; #1;
      chk("t3_after_pop_r1", req1_ready, 1);
      chk("t3_after_pop_r0", req0_ready, 0);
      chk("t3_wrap_waddr",   mem_waddr,  0);
      step(); #1;
      chk("t3_refull",    fifo_full,  1);
      chk("t3_refull_r0", req0_ready, 0);
      chk("t3_refull_r1", req1_ready, 0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rd_ready = 1'b1; n = 0; bad = 0;
      for (int cyc = 0; cyc < 5000 && n < WORDS; cyc++) begin
         #1;
         if (rd_valid) begin
            exp_w = (n < WORDS - 1) ? {1'b1, 23'd0, 12'(n + 1)} : 36'h8_0000_0ABC;
            if (rd_data !== exp_w) bad++;
            n++;
         end
         step();
      end
      rd_ready = 1'b0; #1;
      chk("t3_drain_n",     n,   WORDS);
      chk("t3_drain_order", bad, 0);
      chk("t3_drain_empty", fifo_empty, 1);

      // steady push+pop every cycle across the pointer wrap
      s = 0; r = 0; bad = 0; bad_cnt = 0;
      for (int cyc = 0; cyc < 4200; cyc++) begin
         req0_valid = 1'b1; req0_data = {1'b1, 11'd0, 24'(s)};
         rd_ready = 1'b1;
         #1;
         if (cyc >= 3 && fifo_count != 3) bad_cnt++;
         if (rd_valid) begin
            if (rd_data !== {1'b1, 11'd0, 24'(r)}) bad++;
            r++;
         end
         if (req0_ready) s++;
         step();
      end
      req0_valid = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         #1;
         if (rd_valid) begin
            if (rd_data !== {1'b1, 11'd0, 24'(r)}) bad++;
            r++;
         end
         step();
      end
      rd_ready = 1'b0; #1;
      chk("t4_pushed",     s,       4200);
      chk("t4_count_flat", bad_cnt, 0);
      chk("t4_order",      bad,     0);
      chk("t4_popped",     r,       4200);
      chk("t4_empty",      fifo_empty, 1);

      // random back-pressure: held data must not move
      s = 0; r = 0; bad = 0; unstable = 0; hold = 1'b0; prev_data = '0;
      for (int cyc = 0; cyc < 2000 && r < 40; cyc++) begin
         req0_valid = (s < 40); req0_data = {1'b1, 23'd0, 12'(s + 100)};
         rd_ready = 1'($urandom_range(0, 1));
         #1;
         if (hold && (!rd_valid || rd_data !== prev_data)) unstable++;
         hold = rd_valid && !rd_ready;
         prev_data = rd_data;
         if (rd_valid && rd_ready) begin
            if (rd_data !== {1'b1, 23'd0, 12'(r + 100)}) bad++;
            r++;
         end
         if (req0_valid && req0_ready) s++;
         step();
      end
      req0_valid = 1'b0; rd_ready = 1'b0;
      chk("t5_stable", unstable, 0);
      chk("t5_popped", r, 40);
      chk("t5_order",  bad, 0);

      // reset while requester 1 holds an open frame
      req1_valid = 1'b1; req1_data = 36'h0_0000_0111; #1;
      chk("t6_r1_grant", req1_ready, 1);
      step();
      req1_data = 36'h0_0000_0112; req0_valid = 1'b1; req0_data = 36'h8_0000_0222; #1;
      chk("t6_own1_r0", req0_ready, 0);
      chk("t6_own1_r1", req1_ready, 1);
      step();
      req1_valid = 1'b0; #1;
      chk("t6_own1_hold", req0_ready, 0);
      step(); step(); #1;
      chk("t6_pre_valid", rd_valid,   1);
      chk("t6_pre_count", fifo_count, 2);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst_n = 1'b0; #1;
      chk("t6_rst_count", fifo_count, 0);
      chk("t6_rst_valid", rd_valid,   0);
      chk("t6_rst_empty", fifo_empty, 1);
      @(posedge clk); #1 rst_n = 1'b1;
      step();
      req0_valid = 1'b1; req0_data = 36'h8_0000_0333;
      req1_valid = 1'b1; req1_data = 36'h0_0000_0444;
      #1;
      chk("t6_new_r0",    req0_ready, 1);
      chk("t6_new_r1",    req1_ready, 0);
      chk("t6_new_waddr", mem_waddr,  0);
      chk("t6_new_valid", rd_valid,   0);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regs_fifo_arb_ctrl.md
# regs_fifo_arb_ctrl

Controller that turns the shared 4096x36 DFF register memory into a single-clock frame FIFO fed by two write requesters. It arbitrates round-robin at frame granularity, so a frame from one requester is never interleaved with the other. It keeps write/read pointers and occupancy, and drives the memory's write port and registered read port. A valid/ready stage hides the memory's one-cycle read latency. It sits between the two MAC frame sources and the downstream consumer; both memory clocks and resets are tied to this block's clock and reset.

## Interface
- ADDR, 12, memory address width; WORDS must equal 2^ADDR
- WORDS, 4096, memory depth in words
- W_SIZE, 36, word width; bit W_SIZE-1 is the end-of-frame (EOP) flag
- arb_clk  in  1  single clock; also drives the memory's write and read clocks
- arb_rst_n  in  1  reset, asynchronous, active-low; also drives the memory's write and read resets
- req0_valid  in  1  requester 0 has a word
- req0_data  in  W_SIZE  requester 0 word
- req0_ready  out  1  requester 0 word accepted this cycle when valid&ready
- req1_valid / req1_data / req1_ready  same as requester 0
- rd_valid  out  1  rd_data holds the oldest unread word
- rd_data  out  W_SIZE  output word (driven from mem_rdata)
- rd_ready  in  1  consumer pops on rd_valid&rd_ready
- mem_wen  out  1  memory write enable
- mem_waddr  out  ADDR  memory write address
- mem_wdata  out  W_SIZE  memory write data
- mem_raddr  out  ADDR  memory read address (combinational look-ahead)
- mem_rdata  in  W_SIZE  registered memory read data
- fifo_count  out  ADDR+1  words stored and not yet popped
- fifo_full  out  1  fifo_count == WORDS
- fifo_empty  out  1  fifo_count == 0

## Operation
- Arbiter FSM states: IDLE, OWN0, OWN1. A last_grant bit resets to 1, so requester 0 wins first.
- IDLE:
  - grant goes to the valid requester;
  - if both are valid, grant goes to the one that is not last_grant;
  - reqX_ready = granted & !fifo_full.
- Transitions out of IDLE and OWNx:
  - A non-EOP word accepted in IDLE moves to OWNX.
  - An EOP word accepted in IDLE stays in IDLE and sets last_grant=X (single-word frame).
  - In OWNX, reqX_ready = !fifo_full and the other ready = 0.
  - Accepting an EOP word in OWNX returns to IDLE and sets last_grant=X.
- Push on accept: mem_wen=1, mem_waddr=wr_ptr, mem_wdata=reqX_data, then wr_ptr+1. mem_wen, mem_waddr and mem_wdata are combinational from the accept.
- Pop on rd_valid&rd_ready: rd_ptr+1.
- mem_raddr = rd_ptr+1 when popping, else rd_ptr.
- Pointers are ADDR bits and wrap naturally from WORDS-1 to 0.
- fifo_count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- rd_valid is set when at least one stored word has had its write at least two edges earlier and is unread. A write_lag register delays visibility of a write by one cycle; the memory read register adds another.
- An unread word is never overwritten, because push is blocked when full. mem_rdata therefore stays stable while rd_valid&!rd_ready.
- Reset mid-operation: FSM goes to IDLE, pointers and counts clear, partial frames are discarded, and last_grant=1.

## Timing
- Reset values:
  - req0_ready = req1_ready = 0
  - rd_valid = 0
  - mem_wen = 0; mem_waddr = mem_raddr = 0; mem_wdata = 0
  - fifo_count = 0, fifo_empty = 1, fifo_full = 0
- Write-to-read latency: a word accepted at edge E into an empty FIFO gives rd_valid=1 and rd_data=word after edge E+2.
- Back-to-back pop: pop at edge E presents the next word after edge E+1 if it is visible, giving one word per cycle sustained.
- Full: fifo_full rises after the edge that pushes word WORDS. Ready drops the same cycle and stays low until a pop. A pop and a blocked push in the same cycle do not push; the push is accepted in the next cycle.
- Empty with a simultaneous push and pop cannot occur, because rd_valid=0.
- Arbitration decisions take 0 cycles. The grant can change only in IDLE.

## Structure
- The shared define/package holds:
  - ADDR, WORDS, W_SIZE defaults;
  - the EOP bit index (W_SIZE-1);
  - the FSM state encodings IDLE=2'd0, OWN0=2'd1, OWN1=2'd2;
  - DELAYTIME.
- Sub-module rr_frame_arb holds the FSM and last_grant. Its inputs are valids, EOP bits and full; its outputs are readies and the select.
- Pointers, count and the read look-ahead stay in the top level.

## Test plan
- After reset, write one word 0x8_0000_0001 (EOP) from req0 -> rd_valid high 2 cycles later with that data; fifo_count goes 1 then 0 after the pop.
- Both requesters send 3-word frames continuously -> output order is a req0 frame, then a req1 frame, alternating, with no interleaving inside a frame.
- Push 4096 words with rd_ready=0 -> fifo_full=1 and both readies low. One pop -> exactly one more push accepted, with the waddr wrap from 4095 to 0 verified.
- Steady push and pop every cycle -> fifo_count constant and data order preserved across the pointer wrap.
- rd_ready toggled randomly -> rd_data stable while rd_valid&!rd_ready.
- Assert arb_rst_n mid-frame (state OWN1) -> next cycle FSM is IDLE, count 0, rd_valid 0; a new req0 frame is granted first.
